ep_tx_packet_streamer: RTL and testbench
========================================

Name: ep_tx_packet_streamer

Overview:
- Read-side consumer of the transactional BRAM_FIFO. Pops one IN packet from an endpoint FIFO and streams it byte-wise to the USB TX serializer, then waits for the host handshake.
- On ACK the pop transaction is committed. On NAK or timeout it is rolled back, so the next start_i replays the same bytes.
- Sits between the endpoint FIFO's pop port and the packet serializer.

Parameters:
DATA_WID, 8, width of a FIFO entry / TX byte
MAX_PKT_BYTES, 64, wMaxPacketSize; a packet ends after this many bytes or when the FIFO runs empty
CNT_WID, 7, width of byte counter; must hold MAX_PKT_BYTES
TIMEOUT_CYCLES, 1024, cycles to wait in WAIT_HS before treating the packet as lost
MAX_RETRIES, 3, rollback limit (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset; synchronous, active-low (one clock, synchronous active-low reset)
start_i  in  1  request to send one packet; sampled only in IDLE
busy_o  out  1  high in every state except IDLE
fifoDataAvailable_i  in  1  FIFO dataAvailable_o (first-word-fall-through)
fifoData_i  in  DATA_WID  FIFO data_o
fifoPopData_o  out  1  FIFO popData_i
fifoPopTransDone_o  out  1  FIFO popTransDone_i
fifoPopTransSuccess_o  out  1  FIFO popTransSuccess_i
txValid_o  out  1  byte valid toward serializer
txReady_i  in  1  serializer accepts byte
txData_o  out  DATA_WID  byte
txLast_o  out  1  qualifies final byte of packet
txZlp_o  out  1  one-cycle pulse: send zero-length packet
hsAck_i  in  1  host ACK received (pulse)
hsNak_i  in  1  host NAK/error (pulse)
pktSent_o  out  1  one-cycle pulse on commit
pktRetry_o  out  1  one-cycle pulse on rollback
sentBytes_o  out  CNT_WID  bytes in last finished packet; valid from pktSent_o/pktRetry_o onward

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): state IDLE. All outputs 0: busy_o, fifoPop*, txValid_o, txData_o, txLast_o, txZlp_o, pktSent_o, pktRetry_o, sentBytes_o. byteCnt=0, timer=0.
- The FIFO fill transaction of the packet is committed before start_i, so a low fifoDataAvailable_i during STREAM marks end of packet.
- IDLE:
  - start_i && fifoDataAvailable_i -> STREAM.
  - start_i && !fifoDataAvailable_i -> pulse txZlp_o, byteCnt=0 -> WAIT_HS.
- STREAM:
  - Single output register (txData_o/txValid_o).
  - Pop condition: fifoPopData_o = fifoDataAvailable_i && byteCnt<MAX_PKT_BYTES && (!txValid_o || txReady_i).
  - On pop: txData_o<=fifoData_i, txValid_o<=1, byteCnt++.
  - Latency: start_i at cycle 0 -> first pop cycle 1 -> txValid_o cycle 2. Zero-bubble throughput while txReady_i=1.
  - txLast_o (combinational) = txValid_o && (byteCnt==MAX_PKT_BYTES || !fifoDataAvailable_i).
  - txValid_o && txReady_i && txLast_o -> txValid_o<=0, timer=0 -> WAIT_HS.
  - txValid_o/txData_o stay stable while txReady_i=0.
- WAIT_HS:
  - timer increments each cycle.
  - hsAck_i -> COMMIT.
  - hsNak_i, or timer==TIMEOUT_CYCLES-1 -> ROLLBACK.
  - hsAck_i and hsNak_i together -> ROLLBACK (NAK wins).
  - hs* pulses outside WAIT_HS are ignored.
- COMMIT: one cycle; fifoPopTransDone_o=1, fifoPopTransSuccess_o=1, pktSent_o=1, sentBytes_o<=byteCnt -> IDLE.
- ROLLBACK: one cycle; fifoPopTransDone_o=1, fifoPopTransSuccess_o=0, pktRetry_o=1, sentBytes_o<=byteCnt -> IDLE.
- fifoPopData_o is never asserted in the same cycle as fifoPopTransDone_o (FIFO contract).
- Full packet: exactly MAX_PKT_BYTES popped even if more data remains; the remainder belongs to the next packet. An exactly-MAX packet does not append a ZLP (upper layer decides).
- byteCnt is reset to 0 on every IDLE->STREAM/WAIT_HS transition.
- Reset mid-packet: the block returns to IDLE with no trans-done issued. The FIFO is reset by the same rst_n_i.

Optional Feature:
- Macro EP_TX_RETRY_LIMIT_EN.
- Defined:
  - A retry counter (reset 0) counts consecutive rollbacks; any commit clears it.
  - If a rollback would be the (MAX_RETRIES+1)-th consecutive one, COMMIT is taken instead, dropping the packet. That cycle pulses both pktRetry_o and an extra output port retryErr_o (1 bit, reset 0), and clears the counter.
- Undefined: retries are unbounded, and retryErr_o does not exist.

Test Plan:
- Fill 5 bytes 0x11..0x15 + commit; start_i; txReady_i=1; hsAck_i 3 cycles after last -> bytes 0x11..0x15 in order, txLast_o only on 0x15, pktSent_o, sentBytes_o=5, FIFO empty.
- Same 5 bytes, hsNak_i -> pktRetry_o, sentBytes_o=5; second start_i + hsAck_i replays exactly 0x11..0x15, then FIFO empty.
- 70 bytes committed, MAX_PKT_BYTES=64 -> first packet 64 bytes with txLast_o on byte 64; after ACK the second packet carries 6 bytes.
- Empty FIFO, start_i -> txZlp_o one pulse, no txValid_o; no handshake for 1024 cycles -> ROLLBACK, pktRetry_o, sentBytes_o=0.
- 8 bytes, txReady_i toggling 1/0 randomly; rst_n_i low after byte 4 -> all outputs 0 next cycle, state IDLE, no popTransDone pulse.
- With EP_TX_RETRY_LIMIT_EN, MAX_RETRIES=3: 4 consecutive NAKs -> 4th ends in commit with retryErr_o=1, FIFO empty.

Source files
------------

// File: rtl/ep_tx_packet_streamer_if.sv
// ep_tx_packet_streamer_if: byte stream toward the USB TX serializer.
// master drives byte/last/zlp, slave returns ready.
interface ep_tx_packet_streamer_if #(
  parameter int DATA_WID = 8
);
  logic                txValid_o;
  logic                txReady_i;
  logic [DATA_WID-1:0] txData_o;
  logic                txLast_o;
  logic                txZlp_o;

  modport master (
    output txValid_o,
    output txData_o,
    output txLast_o,
    output txZlp_o,
    input  txReady_i
  );

  modport slave (
    input  txValid_o,
    input  txData_o,
    input  txLast_o,
    input  txZlp_o,
    output txReady_i
  );
endinterface

// File: rtl/ep_tx_packet_streamer.sv
// ep_tx_packet_streamer: pops one IN packet, streams it, commits or replays.
// Optional macro EP_TX_RETRY_LIMIT_EN bounds consecutive rollbacks.
module ep_tx_packet_streamer #(
  parameter int DATA_WID       = 8,
  parameter int MAX_PKT_BYTES  = 64,
  parameter int CNT_WID        = 7,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  output logic                busy_o,
  input  logic                fifoDataAvailable_i,
  input  logic [DATA_WID-1:0] fifoData_i,
  output logic                fifoPopData_o,
  output logic                fifoPopTransDone_o,
  output logic                fifoPopTransSuccess_o,
  ep_tx_packet_streamer_if.master tx,
  input  logic                hsAck_i,
  input  logic                hsNak_i,
  output logic                pktSent_o,
  output logic                pktRetry_o,
  output logic [CNT_WID-1:0]  sentBytes_o
`ifdef EP_TX_RETRY_LIMIT_EN
  ,
  output logic                retryErr_o
`endif
);

  localparam int TMR_WID = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WID-1:0] MAX_CNT =
    CNT_WID'(MAX_PKT_BYTES);
  localparam logic [TMR_WID-1:0] TMO_LAST =
    TMR_WID'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    WAIT_HS,
    COMMIT,
    ROLLBACK
  } state_t;

  state_t              r_state;
  logic [CNT_WID-1:0]  r_cnt;
  logic [TMR_WID-1:0]  r_timer;
  logic                r_txValid;
  logic [DATA_WID-1:0] r_txData;
  logic                r_txZlp;
  logic                r_done;
  logic                r_succ;
  logic                r_sent;
  logic                r_retry;
  logic [CNT_WID-1:0]  r_sentBytes;

`ifdef EP_TX_RETRY_LIMIT_EN
  localparam int RTY_WID = $clog2(MAX_RETRIES + 1) + 1;
  logic [RTY_WID-1:0]  r_retries;
  logic                r_retryErr;
`endif

  logic w_pop;
  logic w_last;
  logic w_tmo;

  assign w_pop = (r_state == STREAM)
              && fifoDataAvailable_i
              && (r_cnt < MAX_CNT)
              && (!r_txValid || tx.txReady_i);

  // FIFO running dry marks the end: its fill was committed before start
  assign w_last = r_txValid
               && ((r_cnt == MAX_CNT) || !fifoDataAvailable_i);

  assign w_tmo = (r_timer == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_txValid   <= 1'b0;
      r_txData    <= '0;
      r_txZlp     <= 1'b0;
      r_done      <= 1'b0;
      r_succ      <= 1'b0;
      r_sent      <= 1'b0;
      r_retry     <= 1'b0;
      r_sentBytes <= '0;
`ifdef EP_TX_RETRY_LIMIT_EN
      r_retries   <= '0;
      r_retryErr  <= 1'b0;
`endif
    end else begin
      r_txZlp <= 1'b0;
      r_done  <= 1'b0;
      r_succ  <= 1'b0;
      r_sent  <= 1'b0;
      r_retry <= 1'b0;
`ifdef EP_TX_RETRY_LIMIT_EN
      r_retryErr <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cnt   <= '0;
            r_timer <= '0;
            if (fifoDataAvailable_i) begin
              r_state <= STREAM;
            end else begin
              r_txZlp <= 1'b1;
              r_state <= WAIT_HS;
            end
          end
        end
        STREAM: begin
          if (r_txValid && tx.txReady_i && w_last) begin
            r_txValid <= 1'b0;
            r_timer   <= '0;
            r_state   <= WAIT_HS;
          end else if (w_pop) begin
            r_txData  <= fifoData_i;
            r_txValid <= 1'b1;
            r_cnt     <= r_cnt + 1'b1;
          end else if (tx.txReady_i) begin
            r_txValid <= 1'b0;
          end
        end
        WAIT_HS: begin
          r_timer <= r_timer + 1'b1;
          if (hsNak_i || w_tmo) begin
            r_done      <= 1'b1;
            r_retry     <= 1'b1;
            r_sentBytes <= r_cnt;
`ifdef EP_TX_RETRY_LIMIT_EN
            // out of retries: drop the packet by committing the pop
            if (r_retries == RTY_WID'(MAX_RETRIES)) begin
              r_succ     <= 1'b1;
              r_retryErr <= 1'b1;
              r_retries  <= '0;
              r_state    <= COMMIT;
            end else begin
              r_retries  <= r_retries + 1'b1;
              r_state    <= ROLLBACK;
            end
`else
            r_state <= ROLLBACK;
`endif
          end else if (hsAck_i) begin
            r_done      <= 1'b1;
            r_succ      <= 1'b1;
            r_sent      <= 1'b1;
            r_sentBytes <= r_cnt;
            r_state     <= COMMIT;
`ifdef EP_TX_RETRY_LIMIT_EN
            r_retries   <= '0;
`endif
          end
        end
        COMMIT:   r_state <= IDLE;
        ROLLBACK: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign busy_o                = (r_state != IDLE);
  assign fifoPopData_o         = w_pop;
  assign fifoPopTransDone_o    = r_done;
  assign fifoPopTransSuccess_o = r_succ;
  assign pktSent_o             = r_sent;
  assign pktRetry_o            = r_retry;
  assign sentBytes_o           = r_sentBytes;

  assign tx.txValid_o = r_txValid;
  assign tx.txData_o  = r_txData;
  assign tx.txLast_o  = w_last;
  assign tx.txZlp_o   = r_txZlp;

`ifdef EP_TX_RETRY_LIMIT_EN
  assign retryErr_o = r_retryErr;
`endif

endmodule

// File: tb/tb_ep_tx_packet_streamer.sv
// tb_ep_tx_packet_streamer: directed bench with a transactional FIFO model.
// Define EP_TX_RETRY_LIMIT_EN to also exercise the retry limit.
module tb_ep_tx_packet_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       avail;
  logic [7:0] fdata;
  logic       pop;
  logic       done;
  logic       succ;
  logic       hsAck;
  logic       hsNak;
  logic       sent;
  logic       retry;
  logic [6:0] sbytes;
`ifdef EP_TX_RETRY_LIMIT_EN
  logic       rerr;
`endif
  logic       fill_en;
  logic [7:0] fill_d;
  logic       rdy_mode;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ep_tx_packet_streamer_if #(.DATA_WID(8)) tx_if ();

  ep_tx_packet_streamer dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .start_i               (start),
    .busy_o                (busy),
    .fifoDataAvailable_i   (avail),
    .fifoData_i            (fdata),
    .fifoPopData_o         (pop),
    .fifoPopTransDone_o    (done),
    .fifoPopTransSuccess_o (succ),
    .tx                    (tx_if),
    .hsAck_i               (hsAck),
    .hsNak_i               (hsNak),
    .pktSent_o             (sent),
    .pktRetry_o            (retry),
    .sentBytes_o           (sbytes)
`ifdef EP_TX_RETRY_LIMIT_EN
    ,
    .retryErr_o            (rerr)
`endif
  );

  // transactional FIFO: rp is speculative, rc the committed read pointer
  logic [7:0] mem [0:255];
  logic [7:0] wp, rp, rc;
  assign avail = (rp != wp);
  assign fdata = mem[rp];

  always @(posedge clk) begin
    if (!rst_n) begin
      wp <= 8'd0;
      rp <= 8'd0;
      rc <= 8'd0;
    end else begin
      if (fill_en) begin
        mem[wp] <= fill_d;
        wp      <= wp + 8'd1;
      end
      if (pop) rp <= rp + 8'd1;
      if (done) begin
        if (succ) rc <= rp;
        else      rp <= rc;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    tx_if.txReady_i = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0] rxq [$];
  bit         lastq [$];
  int zlp_n = 0, sent_n = 0, retry_n = 0, done_n = 0;
  int valid_n = 0, ovl_n = 0, stab_n = 0, err_n = 0, last_sb = -1;
  logic       pst = 1'b0;
  logic [7:0] pdat = 8'd0;

  always @(negedge clk) begin
    if (tx_if.txValid_o === 1'b1 && tx_if.txReady_i === 1'b1) begin
      rxq.push_back(tx_if.txData_o);
      lastq.push_back(tx_if.txLast_o === 1'b1);
    end
    if (pst && rst_n &&
        (tx_if.txValid_o !== 1'b1 || tx_if.txData_o !== pdat))
      stab_n++;
    pst  = rst_n && tx_if.txValid_o === 1'b1 && tx_if.txReady_i === 1'b0;
    pdat = tx_if.txData_o;
    if (tx_if.txValid_o === 1'b1) valid_n++;
    if (tx_if.txZlp_o === 1'b1) zlp_n++;
    if (sent === 1'b1) sent_n++;
    if (retry === 1'b1) retry_n++;
    if (done === 1'b1) done_n++;
    if (sent === 1'b1 || retry === 1'b1) last_sb = int'(sbytes);
    if (pop === 1'b1 && done === 1'b1) ovl_n++;
`ifdef EP_TX_RETRY_LIMIT_EN
    if (rerr === 1'b1) err_n++;
`endif
  end

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      fill_en = 1'b1;
      fill_d  = 8'(base + i);
    end
    @(posedge clk); #1;
    fill_en = 1'b0;
  endtask

  task automatic run_pkt(input bit ack, input bit nak,
                         output bit ok, output int fp, output int fv);
    bit got_last = 0;
    bit got_end  = 0;
    fp = -1;
    fv = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (pop === 1'b1 && fp < 0) fp = k;
      if (tx_if.txValid_o === 1'b1 && fv < 0) fv = k;
      if (tx_if.txValid_o === 1'b1 && tx_if.txReady_i === 1'b1 &&
          tx_if.txLast_o === 1'b1) begin
        got_last = 1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    hsAck = ack;
    hsNak = nak;
    @(posedge clk); #1;
    hsAck = 1'b0;
    hsNak = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sent === 1'b1 || retry === 1'b1) begin
        got_end = 1;
        break;
      end
    end
    @(posedge clk); #1;
    ok = got_last && got_end;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hsAck = 1'b0; hsNak = 1'b0;
    fill_en = 1'b0; fill_d = 8'd0; rdy_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, pop, done, succ} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000", {busy, pop, done, succ});
    end
    checks++;
    if ({tx_if.txValid_o, tx_if.txLast_o, tx_if.txZlp_o, tx_if.txData_o}
        !== 11'd0) begin
      errors++;
      $display("FAIL reset_tx: got v%b l%b z%b d%h want 0",
               tx_if.txValid_o, tx_if.txLast_o, tx_if.txZlp_o,
               tx_if.txData_o);
    end
    checks++;
    if ({sent, retry, sbytes} !== 9'd0) begin
      errors++;
      $display("FAIL reset_pkt: got s%b r%b n%0d want 0",
               sent, retry, sbytes);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ack();
    bit ok; int fp, fv, r0, s0, bad, lpos, lcnt;
    fill(5, 'h11);
    r0 = rxq.size(); s0 = sent_n;
    run_pkt(1, 0, ok, fp, fv);
    checks++;
    if (!ok) begin errors++; $display("FAIL ack_done: got 0 want 1"); end
    checks++;
    if (fp != 0 || fv != 1) begin
      errors++;
      $display("FAIL ack_latency: got pop@%0d valid@%0d want 0/1", fp, fv);
    end
    checks++;
    if (rxq.size() - r0 != 5) begin
      errors++;
      $display("FAIL ack_count: got %0d want 5", rxq.size() - r0);
    end
    bad = 0; lcnt = 0; lpos = -1;
    for (int i = 0; i < 5 && r0 + i < rxq.size(); i++) begin
      if (rxq[r0 + i] !== 8'(8'h11 + i)) bad++;
      if (lastq[r0 + i]) begin lcnt++; lpos = i; end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ack_bytes: got %0d wrong want 0", bad);
    end
    checks++;
    if (lcnt != 1 || lpos != 4) begin
      errors++;
      $display("FAIL ack_last: got %0d at %0d want 1 at 4", lcnt, lpos);
    end
    checks++;
    if (sent_n - s0 != 1 || last_sb != 5) begin
      errors++;
      $display("FAIL ack_sent: got %0d/%0d want 1/5", sent_n - s0, last_sb);
    end
    checks++;
    if (avail !== 1'b0 || rc !== wp) begin
      errors++;
      $display("FAIL ack_empty: got avail %b rc %0d wp %0d want 0 equal",
               avail, rc, wp);
    end
  endtask

  task automatic test_nak_replay();
    bit ok; int fp, fv, r0, s0, q0, bad;
    fill(5, 'h11);
    s0 = sent_n; q0 = retry_n;
    run_pkt(0, 1, ok, fp, fv);
    checks++;
    if (!ok || retry_n - q0 != 1 || sent_n != s0 || last_sb != 5) begin
      errors++;
      $display("FAIL nak_retry: got ok%0d r%0d s%0d n%0d want 1 1 0 5",
               ok, retry_n - q0, sent_n - s0, last_sb);
    end
    checks++;
    if (avail !== 1'b1 || rp !== rc) begin
      errors++;
      $display("FAIL nak_rollback: got avail %b want 1", avail);
    end
    r0 = rxq.size();
    run_pkt(1, 0, ok, fp, fv);
    bad = (rxq.size() - r0 == 5) ? 0 : 99;
    for (int i = 0; i < 5 && r0 + i < rxq.size(); i++)
      if (rxq[r0 + i] !== 8'(8'h11 + i)) bad++;
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL nak_replay: got ok%0d bad%0d want 1 0", ok, bad);
    end
    checks++;
    if (avail !== 1'b0 || sent_n - s0 != 1) begin
      errors++;
      $display("FAIL nak_empty: got avail %b sent %0d want 0 1",
               avail, sent_n - s0);
    end
  endtask

  task automatic test_max_pkt();
    bit ok; int fp, fv, r0, bad, lcnt, lpos;
    fill(70, 0);
    r0 = rxq.size();
    run_pkt(1, 0, ok, fp, fv);
    bad = 0; lcnt = 0; lpos = -1;
    for (int i = 0; r0 + i < rxq.size(); i++) begin
      if (rxq[r0 + i] !== 8'(i)) bad++;
      if (lastq[r0 + i]) begin lcnt++; lpos = i; end
    end
    checks++;
    if (!ok || rxq.size() - r0 != 64 || bad != 0) begin
      errors++;
      $display("FAIL max_first: got ok%0d n%0d bad%0d want 1 64 0",
               ok, rxq.size() - r0, bad);
    end
    checks++;
    if (lcnt != 1 || lpos != 63 || last_sb != 64) begin
      errors++;
      $display("FAIL max_last: got %0d at %0d sb%0d want 1 at 63 sb64",
               lcnt, lpos, last_sb);
    end
    checks++;
    if (avail !== 1'b1) begin
      errors++;
      $display("FAIL max_remain: got avail %b want 1", avail);
    end
    r0 = rxq.size();
    run_pkt(1, 0, ok, fp, fv);
    bad = 0;
    for (int i = 0; r0 + i < rxq.size(); i++)
      if (rxq[r0 + i] !== 8'(64 + i)) bad++;
    checks++;
    if (!ok || rxq.size() - r0 != 6 || bad != 0 || last_sb != 6 ||
        avail !== 1'b0) begin
      errors++;
      $display("FAIL max_second: got ok%0d n%0d bad%0d sb%0d want 1 6 0 6",
               ok, rxq.size() - r0, bad, last_sb);
    end
  endtask

  task automatic test_zlp_timeout();
    int z0, v0, q0, kk;
    logic zlp0 = 1'b0;
    z0 = zlp_n; v0 = valid_n; q0 = retry_n; kk = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (k == 0) zlp0 = tx_if.txZlp_o;
      if (retry === 1'b1) begin kk = k; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (zlp0 !== 1'b1 || zlp_n - z0 != 1 || valid_n != v0) begin
      errors++;
      $display("FAIL zlp_pulse: got z%b n%0d v%0d want 1 1 0",
               zlp0, zlp_n - z0, valid_n - v0);
    end
    checks++;
    if (kk != 1024) begin
      errors++;
      $display("FAIL zlp_timeout: got %0d want 1024 cycles", kk);
    end
    checks++;
    if (retry_n - q0 != 1 || last_sb != 0) begin
      errors++;
      $display("FAIL zlp_retry: got r%0d sb%0d want 1 0",
               retry_n - q0, last_sb);
    end
  endtask

  task automatic test_hs_corner();
    bit ok; int fp, fv, s0, q0;
    s0 = sent_n; q0 = retry_n;
    @(posedge clk); #1;
    hsAck = 1'b1; hsNak = 1'b1;
    @(posedge clk); #1;
    hsAck = 1'b0; hsNak = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sent_n != s0 || retry_n != q0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_idle: got s%0d r%0d busy%b want 0 0 0",
               sent_n - s0, retry_n - q0, busy);
    end
    fill(2, 'hA0);
    run_pkt(1, 1, ok, fp, fv);
    checks++;
    if (!ok || retry_n - q0 != 1 || sent_n != s0 || avail !== 1'b1) begin
      errors++;
      $display("FAIL hs_both: got ok%0d r%0d s%0d av%b want 1 1 0 1",
               ok, retry_n - q0, sent_n - s0, avail);
    end
    run_pkt(1, 0, ok, fp, fv);
    checks++;
    if (!ok || avail !== 1'b0 || ovl_n != 0) begin
      errors++;
      $display("FAIL hs_drain: got ok%0d av%b ovl%0d want 1 0 0",
               ok, avail, ovl_n);
    end
  endtask

  task automatic test_reset_mid();
    int d0, n;
    bit hit = 0;
    fill(8, 'h30);
    rdy_mode = 1'b1;
    d0 = done_n; n = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_if.txValid_o === 1'b1 && tx_if.txReady_i === 1'b1) n++;
      if (n == 4) begin hit = 1; break; end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    checks++;
    if (!hit || stab_n != 0) begin
      errors++;
      $display("FAIL mid_stream: got hit%0d unstable%0d want 1 0",
               hit, stab_n);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, pop, done, succ, sent, retry} !== 6'b0 ||
        {tx_if.txValid_o, tx_if.txLast_o, tx_if.txZlp_o} !== 3'b0 ||
        tx_if.txData_o !== 8'd0 || sbytes !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset: got b%b v%b d%h n%0d want all 0",
               busy, tx_if.txValid_o, tx_if.txData_o, sbytes);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_n != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone: got %0d done pulses busy%b want 0 0",
               done_n - d0, busy);
    end
  endtask

`ifdef EP_TX_RETRY_LIMIT_EN
  task automatic test_retry_limit();
    bit ok; bit allok = 1; int fp, fv, e0, q0, s0;
    fill(3, 'h50);
    e0 = err_n; q0 = retry_n; s0 = sent_n;
    for (int i = 0; i < 3; i++) begin
      run_pkt(0, 1, ok, fp, fv);
      allok = allok && ok;
    end
    checks++;
    if (!allok || avail !== 1'b1 || err_n != e0) begin
      errors++;
      $display("FAIL retry_three: got ok%0d av%b err%0d want 1 1 0",
               allok, avail, err_n - e0);
    end
    run_pkt(0, 1, ok, fp, fv);
    checks++;
    if (!ok || retry_n - q0 != 4 || err_n - e0 != 1 || sent_n != s0) begin
      errors++;
      $display("FAIL retry_limit: got ok%0d r%0d e%0d s%0d want 1 4 1 0",
               ok, retry_n - q0, err_n - e0, sent_n - s0);
    end
    checks++;
    if (avail !== 1'b0 || rc !== wp) begin
      errors++;
      $display("FAIL retry_drop: got avail %b want 0", avail);
    end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ack();
    test_nak_replay();
    test_max_pkt();
    test_zlp_timeout();
    test_hs_corner();
    test_reset_mid();
`ifdef EP_TX_RETRY_LIMIT_EN
    test_retry_limit();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
